// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice.
// Contents:
//   XLEN           default address/instruction width
//   OPC_*          RV32 major opcode constants
//   *_LSB / *_W    bit positions of the opcode/funct3/funct7 fields
//   fetch_state_t  fetch FSM states (IDLE, REQ, WAIT, DROP)
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_W   = 7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instr} pairs between the fetch FSM and decode.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 empties the queue; overrides push/pop that cycle
//   push, push_pc/instr   write one entry
//   pop                   discard the head entry (ignored when empty)
//   count                 number of valid entries (0..QDEPTH)
//   head_valid/pc/instr   head entry; pc/instr read as 0 when empty
module fetch_queue #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned QDEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [XLEN-1:0]            push_pc,
    input  logic [XLEN-1:0]            push_instr,
    input  logic                       pop,
    output logic [$clog2(QDEPTH):0]    count,
    output logic                       head_valid,
    output logic [XLEN-1:0]            head_pc,
    output logic [XLEN-1:0]            head_instr
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    logic [XLEN-1:0] pc_mem    [QDEPTH];
    logic [XLEN-1:0] instr_mem [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            pop_eff;
    logic            push_eff;

    // A push into a full queue is only accepted when the head leaves the
    // same cycle, so count can never exceed QDEPTH.
    always_comb begin
        pop_eff  = pop && (count != '0);
        push_eff = push && ((count != QFULL) || pop_eff);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_eff) - CW'(pop_eff);
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push_eff) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    always_comb begin
        head_valid = (count != '0);
        head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
        head_instr = head_valid ? instr_mem[rd_ptr] : '0;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory, buffers returned words and presents the head
// instruction with its decoded fields to decode.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   imem_req/addr/ready          read request handshake (one outstanding)
//   imem_rvalid/rdata            read response, one per accepted request
//   redirect_valid/pc            restart fetch at redirect_pc (bits [1:0] ignored)
//   dec_valid/ready              head instruction handshake to decode
//   dec_pc/instr                 head instruction and its PC (0 when empty)
//   opcode/funct3/funct7         fields of dec_instr
module instr_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
);

    import riscv_pkg::*;

    localparam int unsigned     CW         = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0]   QFULL      = CW'(QDEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after;
    logic            push;
    logic            pop;

    assign redirect_target = redirect_pc & ALIGN_MASK;
    assign imem_addr       = pc;

    // State register, PC and the PC of the request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC & ALIGN_MASK;
            req_pc <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (imem_req && imem_ready) begin
                req_pc <= pc;
            end
        end
    end

    // Next state and next PC. A redirect always wins over the sequential
    // increment; once a request has been accepted its response must still
    // be absorbed (DROP) before a new request may be issued.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        count_after = count + CW'(push) - CW'(pop);
        unique case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end else if (count < QFULL) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (imem_ready) begin
                        state_next = DROP;
                    end
                end else if (imem_ready) begin
                    pc_next    = pc + PC_STEP;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    state_next = (count_after < QFULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
                // The stale response retires the outstanding request even
                // if a further redirect arrives in the same cycle.
                if (imem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs and queue controls; a redirect suppresses push and pop.
    always_comb begin
        imem_req = (state == REQ);
        push     = (state == WAIT) && imem_rvalid && !redirect_valid;
        pop      = dec_valid && dec_ready && !redirect_valid;
    end

    fetch_queue #(
        .XLEN   (XLEN),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (req_pc),
        .push_instr (imem_rdata),
        .pop        (pop),
        .count      (count),
        .head_valid (dec_valid),
        .head_pc    (dec_pc),
        .head_instr (dec_instr)
    );

    assign opcode = dec_instr[OPCODE_LSB +: OPCODE_W];
    assign funct3 = dec_instr[FUNCT3_LSB +: FUNCT3_W];
    assign funct7 = dec_instr[FUNCT7_LSB +: FUNCT7_W];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Each table row gives the inputs for one
// cycle and the outputs expected during that cycle (state from the previous
// edge); inputs change on the falling edge and outputs are sampled 1ns later.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    always #5 clk = ~clk;

    instr_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        drdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t        vecs[$];
    int unsigned passed = 0;
    int unsigned total  = 0;

    localparam logic [31:0] I0 = 32'h0020_81B3; // add x3,x1,x2
    localparam logic [31:0] I1 = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] I2 = 32'hFE00_0EE3; // branch, funct7=0x7F
    localparam logic [31:0] I3 = 32'h40B5_0533; // sub, funct7=0x20
    localparam logic [31:0] I4 = 32'h0040_A103; // lw, funct3=2
    localparam logic [31:0] I5 = 32'h0000_006F; // jal
    localparam logic [31:0] I6 = 32'h0000_0037; // lui
    localparam logic [31:0] I7 = 32'h0000_0017; // auipc
    localparam logic [31:0] A1 = 32'h00B5_0513;
    localparam logic [31:0] A2 = 32'h00C5_0533;

    function automatic vec_t mk(logic rst, logic rdy, logic rv, logic [31:0] rdata,
                                logic redir, logic [31:0] rpc, logic drdy,
                                logic e_req, logic [31:0] e_addr, logic e_dv,
                                logic [31:0] e_pc, logic [31:0] e_instr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.redir = redir; v.rpc = rpc; v.drdy = drdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_dv = e_dv;
        v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic redir, input logic [31:0] rpc, input logic drdy);
        @(negedge clk);
        reset          = rst;
        imem_ready     = rdy;
        imem_rvalid    = rv;
        imem_rdata     = rdata;
        redirect_valid = redir;
        redirect_pc    = rpc;
        dec_ready      = drdy;
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [31:0] ei;
        drive(v.rst, v.rdy, v.rv, v.rdata, v.redir, v.rpc, v.drdy);
        ei = v.e_instr;
        chk($sformatf("row%0d imem_req", idx), 32'(imem_req), 32'(v.e_req));
        if (v.e_req) chk($sformatf("row%0d imem_addr", idx), imem_addr, v.e_addr);
        chk($sformatf("row%0d dec_valid", idx), 32'(dec_valid), 32'(v.e_dv));
        chk($sformatf("row%0d dec_pc", idx), dec_pc, v.e_pc);
        chk($sformatf("row%0d dec_instr", idx), dec_instr, ei);
        chk($sformatf("row%0d opcode", idx), 32'(opcode), 32'(ei[6:0]));
        chk($sformatf("row%0d funct3", idx), 32'(funct3), 32'(ei[14:12]));
        chk($sformatf("row%0d funct7", idx), 32'(funct7), 32'(ei[31:25]));
    endtask

    initial begin
        //                 rst rdy rv rdata         rd rpc            dr  req addr          dv pc            instr
        // sequential fetch with decode always ready
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        32'h0)); // 0
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 1, I0,           0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h4,        1, 32'h0,        I0));
        vecs.push_back(mk(0, 1, 1, I1,           0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h8,        1, 32'h4,        I1)); // 5
        vecs.push_back(mk(0, 1, 1, I2,           0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'hC,        1, 32'h8,        I2));
        // decode stalls: queue fills, fetch parks in IDLE, then resumes
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0,  1, 32'hC,        1, 32'h8,        I2));
        vecs.push_back(mk(0, 1, 1, I3,           0, 32'h0,        0,  0, 32'h0,        1, 32'h8,        I2));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 32'h8,        I2)); // 10
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 32'h8,        I2));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 32'h8,        I2));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 32'hC,        I3));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0,  1, 32'h10,       1, 32'hC,        I3));
        // redirect while waiting: flush, stale word dropped, restart at 0x100
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h100,      0,  0, 32'h0,        1, 32'hC,        I3)); // 15
        vecs.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0,  1, 32'h100,      0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, I4,           0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h104,      1, 32'h100,      I4));
        // redirect together with rvalid (low bits ignored), then redirect on accept
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0,  1, 32'h104,      1, 32'h100,      I4)); // 20
        vecs.push_back(mk(0, 0, 1, 32'h12345678, 1, 32'h203,      0,  0, 32'h0,        1, 32'h100,      I4));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h200,      0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h202,      0,  1, 32'h200,      0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, 32'hBADBAD00, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0)); // 25
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0,  1, 32'h200,      0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, I5,           0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0));
        // memory not ready for 5 cycles; dec_ready on empty queue ignored
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h204,      1, 32'h200,      I5));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h204,      0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h204,      0, 32'h0,        32'h0)); // 30
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h204,      0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h204,      0, 32'h0,        32'h0));
        // PC wrap from 0xFFFF_FFFC to 0
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0,  1, 32'h204,      0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0,  1, 32'hFFFFFFFC, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, I6,           0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0)); // 35
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        1, 32'hFFFFFFFC, I6));
        vecs.push_back(mk(0, 0, 1, I7,           0, 32'h0,        0,  0, 32'h0,        1, 32'hFFFFFFFC, I6));
        // stray rvalid in IDLE, then reset with a full queue
        vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFF, 0, 32'h0,        0,  0, 32'h0,        1, 32'hFFFFFFFC, I6));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 32'hFFFFFFFC, I6));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0)); // 40
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        0, 32'h0,        32'h0));

        reset          = 1'b1;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Push and pop in the same cycle with one entry queued: count holds at 1.
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
        chk("pp accept req", 32'(imem_req), 32'd1);
        chk("pp accept addr", imem_addr, 32'h0);
        drive(0, 0, 1, A1, 0, 32'h0, 0);
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
        chk("pp head0 pc", dec_pc, 32'h0);
        drive(0, 0, 1, A2, 0, 32'h0, 1);
        chk("pp head0 instr", dec_instr, A1);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        chk("pp head1 pc", dec_pc, 32'h4);
        chk("pp head1 instr", dec_instr, A2);
        chk("pp resume addr", imem_addr, 32'h8);
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
        chk("pp count1 valid", 32'(dec_valid), 32'd1);
        chk("pp count1 pc", dec_pc, 32'h4);

        // Redirects while dropping: stay in DROP until the response, newest PC wins.
        drive(0, 0, 0, 32'h0, 1, 32'h40, 0);
        chk("drop wait req", 32'(imem_req), 32'd0);
        drive(0, 0, 0, 32'h0, 1, 32'h80, 0);
        chk("drop flushed valid", 32'(dec_valid), 32'd0);
        chk("drop hold req", 32'(imem_req), 32'd0);
        drive(0, 0, 1, 32'h55555555, 0, 32'h0, 0);
        chk("drop still req", 32'(imem_req), 32'd0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        chk("drop reissue req", 32'(imem_req), 32'd1);
        chk("drop reissue addr", imem_addr, 32'h80);
        chk("drop no push", 32'(dec_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
